// File: rtl/bsg_manycore_io_responder_pkg.sv
// Shared types for the host-IO responder: FSM states, opcodes, return types and packet layout.
// The packet macro builds request/return structs for a given set of field widths.
package bsg_manycore_io_responder_pkg;

   typedef enum logic {e_init, e_ready} io_resp_state_e;

   localparam int err_cnt_width_gp = 16;
   localparam int reg_id_width_gp  = 5;

   typedef enum logic [1:0] {
      e_remote_load,
      e_remote_store,
      e_remote_amoadd,
      e_remote_amo_other
   } bsg_manycore_packet_op_e;

   typedef enum logic [1:0] {
      e_return_credit,
      e_return_int_wb,
      e_return_float_wb,
      e_return_rsvd
   } bsg_manycore_return_packet_type_e;

   function automatic int bsg_manycore_packet_width(int addr_w, int data_w, int x_w, int y_w);
      return addr_w + 2 + data_w/8 + reg_id_width_gp + data_w + 2*x_w + 2*y_w;
   endfunction

   function automatic int bsg_manycore_return_packet_width(int data_w, int x_w, int y_w);
      return 2 + data_w + reg_id_width_gp + 2*x_w + 2*y_w;
   endfunction

endpackage

`ifndef BSG_MANYCORE_IO_RESPONDER_PKT_MACROS
`define BSG_MANYCORE_IO_RESPONDER_PKT_MACROS
`define DECLARE_BSG_MANYCORE_PACKET_S(addr_w, data_w, x_w, y_w) \
   typedef struct packed { \
      logic [(addr_w)-1:0]          addr; \
      bsg_manycore_packet_op_e      op; \
      logic [(data_w)/8-1:0]        op_ex; \
      logic [reg_id_width_gp-1:0]   reg_id; \
      logic [(data_w)-1:0]          payload; \
      logic [(y_w)-1:0]             src_y_cord; \
      logic [(x_w)-1:0]             src_x_cord; \
      logic [(y_w)-1:0]             y_cord; \
      logic [(x_w)-1:0]             x_cord; \
   } bsg_manycore_packet_s; \
   typedef struct packed { \
      bsg_manycore_return_packet_type_e pkt_type; \
      logic [(data_w)-1:0]          data; \
      logic [reg_id_width_gp-1:0]   reg_id; \
      logic [(y_w)-1:0]             src_y_cord; \
      logic [(x_w)-1:0]             src_x_cord; \
      logic [(y_w)-1:0]             y_cord; \
      logic [(x_w)-1:0]             x_cord; \
   } bsg_manycore_return_packet_s
`endif

// File: rtl/bsg_mem_1rw_sync_mask_write_byte.sv
// Word scratchpad with byte-masked synchronous write and registered read.
// A read and a write may land on the same edge; the read returns the pre-write contents.
module bsg_mem_1rw_sync_mask_write_byte #(
   parameter int els_p         = 256,
   parameter int data_width_p  = 32,
   localparam int addr_width_lp = $clog2(els_p),
   localparam int mask_width_lp = data_width_p/8
) (
   input  logic                     clk_i,
   input  logic                     reset_n_i,
   input  logic                     r_v_i,
   input  logic [addr_width_lp-1:0] r_addr_i,
   input  logic                     w_v_i,
   input  logic [addr_width_lp-1:0] w_addr_i,
   input  logic [data_width_p-1:0]  w_data_i,
   input  logic [mask_width_lp-1:0] w_mask_i,
   output logic [data_width_p-1:0]  data_o
);

   logic [data_width_p-1:0] mem_q [els_p];
   logic [data_width_p-1:0] data_q;

   always_ff @(posedge clk_i) begin
      for (int b = 0; b < mask_width_lp; b++) begin
         if (w_v_i && w_mask_i[b])
            mem_q[w_addr_i][8*b +: 8] <= w_data_i[8*b +: 8];
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i)  data_q <= '0;
      else if (r_v_i)  data_q <= mem_q[r_addr_i];
   end

   assign data_o = data_q;

endmodule

// File: rtl/bsg_manycore_io_responder.sv
// Host-IO responder: scratchpad-backed endpoint answering every load/store/amoadd with one response.
// Optional BSG_IO_RESPONDER_TRACE_EN prints accepted requests and errors (no logic change).
module bsg_manycore_io_responder
   import bsg_manycore_io_responder_pkg::*;
#(
   parameter int addr_width_p   = 12,
   parameter int data_width_p   = 32,
   parameter int x_cord_width_p = 4,
   parameter int y_cord_width_p = 4,
   parameter int els_p          = 256,
   localparam int fwd_pkt_width_lp =
      bsg_manycore_packet_width(addr_width_p, data_width_p, x_cord_width_p, y_cord_width_p),
   localparam int rev_pkt_width_lp =
      bsg_manycore_return_packet_width(data_width_p, x_cord_width_p, y_cord_width_p)
) (
   input  logic                        clk_i,
   input  logic                        reset_n_i,
   input  logic [x_cord_width_p-1:0]   my_x_i,
   input  logic [y_cord_width_p-1:0]   my_y_i,
   input  logic [fwd_pkt_width_lp-1:0] fwd_pkt_i,
   input  logic                        fwd_v_i,
   output logic                        fwd_ready_o,
   output logic [rev_pkt_width_lp-1:0] rev_pkt_o,
   output logic                        rev_v_o,
   input  logic                        rev_ready_i,
   output logic                        init_done_o,
   output logic [err_cnt_width_gp-1:0] err_cnt_o
);

   localparam int lg_els_lp     = $clog2(els_p);
   localparam int mask_width_lp = data_width_p/8;

   `DECLARE_BSG_MANYCORE_PACKET_S(addr_width_p, data_width_p, x_cord_width_p, y_cord_width_p);

   bsg_manycore_packet_s        req;
   bsg_manycore_return_packet_s ret;
   assign req = fwd_pkt_i;

   io_resp_state_e              state_q, state_d;
   logic [lg_els_lp-1:0]        init_idx_q;

   logic                        accept, req_bad, req_rd, req_wb;
   logic [lg_els_lp-1:0]        req_idx;

   logic                        mem_w_v;
   logic [lg_els_lp-1:0]        mem_w_addr;
   logic [data_width_p-1:0]     mem_w_data, mem_r_data;
   logic [mask_width_lp-1:0]    mem_w_mask;

   // response stage
   logic                        rev_v_q, rd_sel_q, fresh_q;
   bsg_manycore_return_packet_type_e ret_type_q;
   logic [reg_id_width_gp-1:0]  ret_reg_q;
   logic [x_cord_width_p-1:0]   ret_x_q, ret_src_x_q;
   logic [y_cord_width_p-1:0]   ret_y_q, ret_src_y_q;
   logic                        wr_store_q, wr_amo_q;
   logic [lg_els_lp-1:0]        wr_idx_q;
   logic [data_width_p-1:0]     wr_data_q;
   logic [mask_width_lp-1:0]    wr_mask_q;
   logic                        byp_v_q;
   logic [data_width_p-1:0]     byp_data_q;
   logic [mask_width_lp-1:0]    byp_mask_q;
   logic [err_cnt_width_gp-1:0] err_cnt_q;

   logic                        wr_v;
   logic [data_width_p-1:0]     old_word, wr_word;
   logic [mask_width_lp-1:0]    wr_mask;

   logic unused_dst;
   assign unused_dst = ^{req.y_cord, req.x_cord};

   assign req_idx = req.addr[lg_els_lp-1:0];
   assign req_bad = ((req.addr >> lg_els_lp) != '0) || (req.op == e_remote_amo_other);
   assign req_rd  = !req_bad && (req.op == e_remote_load || req.op == e_remote_amoadd);
   assign req_wb  = req_bad || (req.op != e_remote_store);
   assign accept  = fwd_v_i && fwd_ready_o;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) state_q <= e_init;
      else            state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (state_q == e_init && init_idx_q == lg_els_lp'(els_p-1)) state_d = e_ready;
   end

   always_comb begin
      fwd_ready_o = 1'b0;
      init_done_o = 1'b0;
      mem_w_v     = 1'b0;
      mem_w_addr  = wr_idx_q;
      mem_w_data  = wr_word;
      mem_w_mask  = wr_mask;
      case (state_q)
         e_init: begin
            mem_w_v    = 1'b1;
            mem_w_addr = init_idx_q;
            mem_w_data = '0;
            mem_w_mask = '1;
         end
         e_ready: begin
            fwd_ready_o = !rev_v_q || rev_ready_i;
            init_done_o = 1'b1;
            mem_w_v     = wr_v;
         end
         default: ;
      endcase
   end

   // Memory read is pre-write, so the previous request's write is merged here.
   always_comb begin
      old_word = mem_r_data;
      for (int b = 0; b < mask_width_lp; b++) begin
         if (byp_v_q && byp_mask_q[b]) old_word[8*b +: 8] = byp_data_q[8*b +: 8];
      end
   end

   assign wr_v    = fresh_q && (wr_store_q || wr_amo_q);
   assign wr_word = wr_amo_q ? old_word + wr_data_q : wr_data_q;
   assign wr_mask = wr_amo_q ? '1 : wr_mask_q;

   bsg_mem_1rw_sync_mask_write_byte #(
      .els_p        (els_p),
      .data_width_p (data_width_p)
   ) mem (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .r_v_i     (accept && req_rd),
      .r_addr_i  (req_idx),
      .w_v_i     (mem_w_v),
      .w_addr_i  (mem_w_addr),
      .w_data_i  (mem_w_data),
      .w_mask_i  (mem_w_mask),
      .data_o    (mem_r_data)
   );

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         init_idx_q  <= '0;
         rev_v_q     <= 1'b0;
         rd_sel_q    <= 1'b0;
         fresh_q     <= 1'b0;
         ret_type_q  <= e_return_credit;
         ret_reg_q   <= '0;
         ret_x_q     <= '0;
         ret_y_q     <= '0;
         ret_src_x_q <= '0;
         ret_src_y_q <= '0;
         wr_store_q  <= 1'b0;
         wr_amo_q    <= 1'b0;
         wr_idx_q    <= '0;
         wr_data_q   <= '0;
         wr_mask_q   <= '0;
         byp_v_q     <= 1'b0;
         byp_data_q  <= '0;
         byp_mask_q  <= '0;
         err_cnt_q   <= '0;
      end else begin
         if (state_q == e_init) init_idx_q <= init_idx_q + lg_els_lp'(1);
         fresh_q <= accept;
         if (accept) begin
            rev_v_q     <= 1'b1;
            rd_sel_q    <= req_rd;
            ret_type_q  <= req_wb ? e_return_int_wb : e_return_credit;
            ret_reg_q   <= req.reg_id;
            ret_x_q     <= req.src_x_cord;
            ret_y_q     <= req.src_y_cord;
            ret_src_x_q <= my_x_i;
            ret_src_y_q <= my_y_i;
            wr_store_q  <= !req_bad && (req.op == e_remote_store);
            wr_amo_q    <= !req_bad && (req.op == e_remote_amoadd);
            wr_idx_q    <= req_idx;
            wr_data_q   <= req.payload;
            wr_mask_q   <= req.op_ex;
            byp_v_q     <= wr_v && (wr_idx_q == req_idx);
            byp_data_q  <= wr_word;
            byp_mask_q  <= wr_mask;
            if (req_bad && err_cnt_q != '1) err_cnt_q <= err_cnt_q + err_cnt_width_gp'(1);
         end else if (rev_ready_i) begin
            rev_v_q <= 1'b0;
         end
      end
   end

   always_comb begin
      ret.pkt_type   = ret_type_q;
      ret.data       = rd_sel_q ? old_word : '0;
      ret.reg_id     = ret_reg_q;
      ret.src_y_cord = ret_src_y_q;
      ret.src_x_cord = ret_src_x_q;
      ret.y_cord     = ret_y_q;
      ret.x_cord     = ret_x_q;
   end

   assign rev_pkt_o = ret;
   assign rev_v_o   = rev_v_q;
   assign err_cnt_o = err_cnt_q;

`ifdef BSG_IO_RESPONDER_TRACE_EN
   always @(posedge clk_i) begin
      if (reset_n_i && accept) begin
         $display("[IO_RESP] t=%0t op=%s addr=%h data=%h src %0d,%0d",
                  $time, req.op.name(), req.addr, req.payload, req.src_x_cord, req.src_y_cord);
         if (req_bad)
            $display("[IO_RESP] t=%0t error addr=%h op=%s", $time, req.addr, req.op.name());
      end
   end
`endif

endmodule
